// File: rtl/serial_ones_tx.sv
// MSB-first word serializer with idle gap insertion and a registered
// golden three-consecutive-ones flag aligned to the serial stream.
module serial_ones_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_word,
  output logic             ready,
  output logic             data_out,
  output logic             valid_out,
  output logic             done,
  output logic             run3
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [1:0]       ones_q, ones_d;
  logic             run3_q, run3_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = 1'b0;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          // MSB goes straight to data_out; the shifter keeps the remainder
          shift_d   = data_word << 1;
          data_d    = data_word[WIDTH-1];
          valid_d   = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bit_cnt_q == BIT_LAST) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          data_d    = shift_q[WIDTH-1];
          valid_d   = 1'b1;
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    done_d = valid_d && (bit_cnt_d == BIT_LAST);
    // Run counter advances with the bit it describes, so run3 lands on that bit
    if (valid_d && data_d) ones_d = (ones_q == 2'd3) ? 2'd3 : ones_q + 2'd1;
    else                   ones_d = 2'd0;
    run3_d = (ones_d == 2'd3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ones_q    <= 2'd0;
      run3_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ones_q    <= ones_d;
      run3_q    <= run3_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign done      = done_q;
  assign run3      = run3_q;

endmodule

// File: tb/tb_serial_ones_tx.sv
// Bench for serial_ones_tx: GAP=2 and GAP=0 instances checked against a
// per-cycle position model of the transmitted frame plus an output-side run detector.
module tb_serial_ones_tx;
  localparam int W = 8;

  logic            clk;
  logic [1:0]      rst, ld;
  logic [1:0][7:0] dw;
  logic [1:0]      rdy, dout, vout, dn, r3;

  int tests, fails;
  int pos [2];
  int gapn[2];
  int det [2];
  logic [7:0] word[2];

  serial_ones_tx #(.WIDTH(W), .GAP(2)) u_a (
    .clk(clk), .reset(rst[0]), .load(ld[0]), .data_word(dw[0]),
    .ready(rdy[0]), .data_out(dout[0]), .valid_out(vout[0]), .done(dn[0]), .run3(r3[0]));

  serial_ones_tx #(.WIDTH(W), .GAP(0)) u_b (
    .clk(clk), .reset(rst[1]), .load(ld[1]), .data_word(dw[1]),
    .ready(rdy[1]), .data_out(dout[1]), .valid_out(vout[1]), .done(dn[1]), .run3(r3[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, d, o, e);
    end
  endtask

  // pos = cycle index within the current frame (1..W word bits, then gap), 0 = idle
  task automatic model_update(input int d);
    if (rst[d]) pos[d] = 0;
    else if (pos[d] == 0) begin
      if (ld[d]) begin
        word[d] = dw[d];
        pos[d]  = 1;
      end
    end else if (pos[d] < W + gapn[d]) pos[d]++;
    else pos[d] = 0;
  endtask

  task automatic check_all(input int d);
    int p;
    logic [7:0] w;
    logic ev, ed, er3;
    p   = pos[d];
    w   = word[d];
    ev  = (p >= 1) && (p <= W);
    ed  = ev ? w[W-p] : 1'b0;
    er3 = ev && (p >= 3) && w[W-p] && w[W-p+1] && w[W-p+2];
    chk("ready", d, rdy[d], p == 0);
    chk("valid", d, vout[d], ev);
    chk("data", d, dout[d], ed);
    chk("done", d, dn[d], p == W);
    chk("run3", d, r3[d], er3);
    if (vout[d] && dout[d]) det[d] = (det[d] == 3) ? 3 : det[d] + 1;
    else                    det[d] = 0;
    chk("run3_vs_detector", d, r3[d], det[d] == 3);
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic run_word(input int d, input logic [7:0] w, input int ncyc);
    ld[d] = 1'b1;
    dw[d] = w;
    step();
    ld[d] = 1'b0;
    repeat (ncyc - 1) step();
  endtask

  initial begin
    logic [7:0] e;
    tests = 0; fails = 0;
    gapn[0] = 2; gapn[1] = 0;
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; det[d] = 0; word[d] = 8'h00;
    end
    rst = 2'b11; ld = 2'b00; dw = '0;
    #1;
    check_all(0);
    check_all(1);
    step();
    ld = 2'b11;
    step();
    ld = 2'b00;
    rst = 2'b00;

    // 0xE7 against the literal expected waveform
    e = 8'hE7;
    ld[0] = 1'b1; dw[0] = e;
    for (int c = 1; c <= 11; c++) begin
      step();
      ld[0] = 1'b0;
      chk("e7_data", 0, dout[0], (c <= 8) ? e[8-c] : 1'b0);
      chk("e7_valid", 0, vout[0], c <= 8);
      chk("e7_run3", 0, r3[0], (c == 3) || (c == 8));
      chk("e7_done", 0, dn[0], c == 8);
      chk("e7_ready", 0, rdy[0], c == 11);
    end

    run_word(0, 8'hFF, 11);
    run_word(0, 8'h00, 11);

    // 0x0F with a load pulse during cycle 4 that must be ignored
    ld[0] = 1'b1; dw[0] = 8'h0F;
    step();
    ld[0] = 1'b0;
    repeat (3) step();
    ld[0] = 1'b1; dw[0] = 8'hFF;
    step();
    ld[0] = 1'b0;
    repeat (9) step();

    // async reset at cycle 5 of 0xFF, then 0x81
    ld[0] = 1'b1; dw[0] = 8'hFF;
    step();
    ld[0] = 1'b0;
    repeat (4) step();
    #2;
    rst[0] = 1'b1;
    pos[0] = 0;
    #1;
    check_all(0);
    chk("rst_async_data", 0, dout[0], 1'b0);
    chk("rst_async_ready", 0, rdy[0], 1'b1);
    step();
    rst[0] = 1'b0;
    e = 8'h81;
    ld[0] = 1'b1; dw[0] = e;
    for (int c = 1; c <= 11; c++) begin
      step();
      ld[0] = 1'b0;
      chk("x81_data", 0, dout[0], (c <= 8) ? e[8-c] : 1'b0);
      chk("x81_done", 0, dn[0], c == 8);
    end

    // GAP=0: load held high, words separated by exactly one idle cycle
    ld[1] = 1'b1; dw[1] = 8'hC3;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("gap0_valid", 1, vout[1], c != 9);
      chk("gap0_ready", 1, rdy[1], c == 9);
      chk("gap0_run3", 1, r3[1], 1'b0);
    end
    ld[1] = 1'b0;
    repeat (2) step();

    // randomized traffic with occasional resets
    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        ld[d]  = ($urandom_range(0, 2) == 0);
        dw[d]  = 8'($urandom);
        rst[d] = ($urandom_range(0, 59) == 0);
      end
      step();
    end
    rst = 2'b00; ld = 2'b00;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
